// File: rtl/qerv_rf_host.sv
// rtl/qerv_rf_host.sv - parallel register commands executed as serial register-file transactions
// Optional feature macro: QERV_RF_HOST_TIMEOUT_EN (15-cycle grant timeout in RWAIT/WREQ).

module qerv_rf_host #(
   parameter int BITS_PER_CYCLE = 1,
   parameter int csr_regs       = 4,
   parameter int raw            = $clog2(32 + csr_regs),
   parameter int N              = 32 / BITS_PER_CYCLE
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_cmd_valid,
   output logic                      o_cmd_ready,
   input  logic                      i_cmd_we,
   input  logic [raw-1:0]            i_cmd_reg,
   input  logic [31:0]               i_cmd_wdata,
   output logic                      o_rsp_valid,
   input  logic                      i_rsp_ready,
   output logic [31:0]               o_rsp_rdata,
   output logic                      o_rsp_err,
   output logic                      o_rreq,
   output logic                      o_wreq,
   input  logic                      i_ready,
   output logic [raw-1:0]            o_rreg0,
   output logic [raw-1:0]            o_rreg1,
   output logic [raw-1:0]            o_wreg0,
   output logic [raw-1:0]            o_wreg1,
   output logic                      o_wen0,
   output logic                      o_wen1,
   output logic [BITS_PER_CYCLE-1:0] o_wdata0,
   output logic [BITS_PER_CYCLE-1:0] o_wdata1,
   input  logic [BITS_PER_CYCLE-1:0] i_rdata0,
   input  logic [BITS_PER_CYCLE-1:0] i_rdata1
);

   localparam int             CW    = $clog2(N);
   localparam logic [raw:0]   NREGS = (raw + 1)'(32 + csr_regs);

   typedef enum logic [2:0] {
      IDLE, RREQ, RWAIT, RSHIFT, WREQ, WSHIFT, RSP
   } state_t;

   state_t          state, state_nxt;
   logic [raw-1:0]  reg_q;
   logic [31:0]     wsr, rsr, rsr_shift;
   logic [CW-1:0]   cnt;
   logic [31:0]     rsp_rdata, rsp_rdata_d;
   logic            rsp_err, rsp_err_d, rsp_set;
   logic            last_beat, illegal, timeout;

   assign rsr_shift = {i_rdata0, rsr[31:BITS_PER_CYCLE]};
   assign last_beat = (cnt == CW'(N - 1));
   assign illegal   = ({1'b0, i_cmd_reg} >= NREGS);

`ifdef QERV_RF_HOST_TIMEOUT_EN
   logic [3:0] wcnt;
   assign timeout = (wcnt == 4'd14);

   // Counts cycles spent waiting for a grant; any state change clears it.
   always_ff @(posedge i_clk) begin
      if (i_rst)
         wcnt <= 4'd0;
      else if ((state == RWAIT || state == WREQ) && state_nxt == state)
         wcnt <= wcnt + 4'd1;
      else
         wcnt <= 4'd0;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      rsp_set     = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = 32'd0;
      case (state)
         IDLE: begin
            if (i_cmd_valid) begin
               if (illegal) begin
                  state_nxt = RSP;
                  rsp_set   = 1'b1;
                  rsp_err_d = 1'b1;
               end else if (i_cmd_we && i_cmd_reg == '0) begin
                  state_nxt = RSP;
                  rsp_set   = 1'b1;
               end else begin
                  state_nxt = i_cmd_we ? WREQ : RREQ;
               end
            end
         end
         RREQ: state_nxt = RWAIT;
         RWAIT: begin
            if (i_ready) begin
               state_nxt = RSHIFT;
            end else if (timeout) begin
               state_nxt = RSP;
               rsp_set   = 1'b1;
               rsp_err_d = 1'b1;
            end
         end
         RSHIFT: begin
            if (last_beat) begin
               state_nxt   = RSP;
               rsp_set     = 1'b1;
               rsp_rdata_d = rsr_shift;
            end
         end
         WREQ: begin
            if (i_ready) begin
               state_nxt = WSHIFT;
            end else if (timeout) begin
               state_nxt = RSP;
               rsp_set   = 1'b1;
               rsp_err_d = 1'b1;
            end
         end
         WSHIFT: begin
            if (last_beat) begin
               state_nxt = RSP;
               rsp_set   = 1'b1;
            end
         end
         RSP: begin
            if (i_rsp_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         reg_q     <= '0;
         wsr       <= 32'd0;
         rsr       <= 32'd0;
         cnt       <= '0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && i_cmd_valid) begin
            reg_q <= i_cmd_reg;
            wsr   <= i_cmd_wdata;
         end else if (state == WSHIFT) begin
            wsr <= wsr >> BITS_PER_CYCLE;
         end
         if (state == RSHIFT)
            rsr <= rsr_shift;
         // Beat counter idles at zero so each shift phase starts from beat 0.
         if (state == RSHIFT || state == WSHIFT)
            cnt <= cnt + CW'(1);
         else
            cnt <= '0;
         if (rsp_set) begin
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
         end else if (state == RSP && i_rsp_ready) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
         end
      end
   end

   assign o_cmd_ready = (state == IDLE);
   assign o_rreq      = (state == RREQ);
   assign o_wreq      = (state == WREQ);
   assign o_wen0      = (state == WSHIFT);
   assign o_wen1      = 1'b0;
   assign o_wdata0    = o_wen0 ? wsr[BITS_PER_CYCLE-1:0] : '0;
   assign o_wdata1    = '0;
   assign o_rsp_valid = (state == RSP);
   assign o_rsp_rdata = rsp_rdata;
   assign o_rsp_err   = rsp_err;
   assign o_rreg0     = reg_q;
   assign o_rreg1     = reg_q;
   assign o_wreg0     = reg_q;
   assign o_wreg1     = reg_q;

   logic unused;
   assign unused = ^{i_rdata1, rsr[BITS_PER_CYCLE-1:0]};

endmodule

// File: tb/tb_qerv_rf_host.sv
// tb/tb_qerv_rf_host.sv - directed vectors for qerv_rf_host at 1 and 4 bits per cycle
// Both DUTs share command inputs; each has its own behavioural register-file RAM model.

module tb_qerv_rf_host;

   logic        clk = 1'b0;
   logic        rst, cmd_valid, cmd_we, rsp_ready, ram_en, mem_clr;
   logic [5:0]  cmd_reg;
   logic [31:0] cmd_wdata;

   logic        cmd_ready_1, rsp_valid_1, rsp_err_1, rreq_1, wreq_1, wen0_1, wen1_1, ready_1;
   logic [31:0] rsp_rdata_1;
   logic [5:0]  rreg0_1, rreg1_1, wreg0_1, wreg1_1;
   logic [0:0]  wdata0_1, wdata1_1, rdata0_1;

   logic        cmd_ready_4, rsp_valid_4, rsp_err_4, rreq_4, wreq_4, wen0_4, wen1_4, ready_4;
   logic [31:0] rsp_rdata_4;
   logic [5:0]  rreg0_4, rreg1_4, wreg0_4, wreg1_4;
   logic [3:0]  wdata0_4, wdata1_4, rdata0_4;

   always #5 clk = ~clk;

   qerv_rf_host #(.BITS_PER_CYCLE(1), .csr_regs(4)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready_1),
      .i_cmd_we(cmd_we), .i_cmd_reg(cmd_reg), .i_cmd_wdata(cmd_wdata),
      .o_rsp_valid(rsp_valid_1), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata_1),
      .o_rsp_err(rsp_err_1), .o_rreq(rreq_1), .o_wreq(wreq_1), .i_ready(ready_1),
      .o_rreg0(rreg0_1), .o_rreg1(rreg1_1), .o_wreg0(wreg0_1), .o_wreg1(wreg1_1),
      .o_wen0(wen0_1), .o_wen1(wen1_1), .o_wdata0(wdata0_1), .o_wdata1(wdata1_1),
      .i_rdata0(rdata0_1), .i_rdata1(1'b0));

   qerv_rf_host #(.BITS_PER_CYCLE(4), .csr_regs(4)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready_4),
      .i_cmd_we(cmd_we), .i_cmd_reg(cmd_reg), .i_cmd_wdata(cmd_wdata),
      .o_rsp_valid(rsp_valid_4), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata_4),
      .o_rsp_err(rsp_err_4), .o_rreq(rreq_4), .o_wreq(wreq_4), .i_ready(ready_4),
      .o_rreg0(rreg0_4), .o_rreg1(rreg1_4), .o_wreg0(wreg0_4), .o_wreg1(wreg1_4),
      .o_wen0(wen0_4), .o_wen1(wen1_4), .o_wdata0(wdata0_4), .o_wdata1(wdata1_4),
      .i_rdata0(rdata0_4), .i_rdata1(4'd0));

   // RAM models: write grant same cycle as wreq, read grant two cycles after rreq.
   logic [31:0] mem1 [0:63];
   logic [31:0] mem4 [0:63];
   logic        rq1_d, gnt1, rb_act1, rq4_d, gnt4, rb_act4;
   int          rb1, wb1, rb4, wb4;
   int          wen_cnt1, rreq_cnt1, wreq_cnt1, wen_cnt4, rreq_cnt4, wreq_cnt4;
   logic [31:0] wcap1, wcap4;

   assign ready_1  = ram_en & (wreq_1 | gnt1);
   assign ready_4  = ram_en & (wreq_4 | gnt4);
   assign rdata0_1 = rb_act1 ? mem1[rreg0_1][rb1 +: 1] : 1'b0;
   assign rdata0_4 = rb_act4 ? mem4[rreg0_4][rb4*4 +: 4] : 4'd0;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 64; i++) begin
            mem1[i] <= 32'd0;
            mem4[i] <= 32'd0;
         end
         {rq1_d, gnt1, rb_act1, rq4_d, gnt4, rb_act4} <= 6'd0;
         {rb1, wb1, rb4, wb4} <= '0;
         {wen_cnt1, rreq_cnt1, wreq_cnt1, wen_cnt4, rreq_cnt4, wreq_cnt4} <= '0;
         wcap1 <= 32'd0;
         wcap4 <= 32'd0;
      end else begin
         rq1_d <= rreq_1; gnt1 <= rq1_d;
         rq4_d <= rreq_4; gnt4 <= rq4_d;
         if (gnt1 && ram_en) begin rb_act1 <= 1'b1; rb1 <= 0; end
         else if (rb_act1) begin rb1 <= rb1 + 1; if (rb1 == 31) rb_act1 <= 1'b0; end
         if (gnt4 && ram_en) begin rb_act4 <= 1'b1; rb4 <= 0; end
         else if (rb_act4) begin rb4 <= rb4 + 1; if (rb4 == 7) rb_act4 <= 1'b0; end
         if (wen0_1) begin
            mem1[wreg0_1][wb1 +: 1] <= wdata0_1;
            wb1 <= wb1 + 1;
            wcap1 <= {wdata0_1, wcap1[31:1]};
            wen_cnt1 <= wen_cnt1 + 1;
         end else wb1 <= 0;
         if (wen0_4) begin
            mem4[wreg0_4][wb4*4 +: 4] <= wdata0_4;
            wb4 <= wb4 + 1;
            wcap4 <= {wdata0_4, wcap4[31:4]};
            wen_cnt4 <= wen_cnt4 + 1;
         end else wb4 <= 0;
         if (rreq_1) rreq_cnt1 <= rreq_cnt1 + 1;
         if (wreq_1) wreq_cnt1 <= wreq_cnt1 + 1;
         if (rreq_4) rreq_cnt4 <= rreq_cnt4 + 1;
         if (wreq_4) wreq_cnt4 <= wreq_cnt4 + 1;
      end
   end

   int vec_cnt = 0;
   int err_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic run_cmd(input logic we, input logic [5:0] rg, input logic [31:0] wd,
                          output logic [31:0] rd1, output logic [31:0] rd4,
                          output logic e1, output logic e4, output int l1, output int l4);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_we = we; cmd_reg = rg; cmd_wdata = wd;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      l1 = 0; l4 = 0;
      for (int c = 1; c <= 300 && (l1 == 0 || l4 == 0); c++) begin
         @(negedge clk);
         if (l1 == 0 && rsp_valid_1) l1 = c;
         if (l4 == 0 && rsp_valid_4) l4 = c;
      end
      rd1 = rsp_rdata_1; e1 = rsp_err_1;
      rd4 = rsp_rdata_4; e4 = rsp_err_4;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [5:0]  rg;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        serial;
      int          exp_lat1;
      int          exp_lat4;
   } vec_t;

   vec_t        vt [13];
   logic [31:0] rd1, rd4;
   logic        e1, e4, ok, found;
   int          l1, l4, w1, r1, q1, w4, r4, q4, beats;

   initial begin
      // exp_lat 0: short-circuit response, accepted within 2 cycles
      vt[0]  = '{1'b1, 6'd5,  32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 34, 10};
      vt[1]  = '{1'b0, 6'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b1, 36, 12};
      vt[2]  = '{1'b1, 6'd33, 32'h12345678, 32'h0,        1'b0, 1'b1, 34, 10};
      vt[3]  = '{1'b0, 6'd33, 32'h0,        32'h12345678, 1'b0, 1'b1, 36, 12};
      vt[4]  = '{1'b1, 6'd0,  32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 1,  1};
      vt[5]  = '{1'b0, 6'd0,  32'h0,        32'h0,        1'b0, 1'b1, 36, 12};
      vt[6]  = '{1'b0, 6'd36, 32'h0,        32'h0,        1'b1, 1'b0, 0,  0};
      vt[7]  = '{1'b1, 6'd63, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 0,  0};
      vt[8]  = '{1'b1, 6'd35, 32'hA5A55A5A, 32'h0,        1'b0, 1'b1, 34, 10};
      vt[9]  = '{1'b0, 6'd35, 32'h0,        32'hA5A55A5A, 1'b0, 1'b1, 36, 12};
      vt[10] = '{1'b1, 6'd31, 32'h80000001, 32'h0,        1'b0, 1'b1, 34, 10};
      vt[11] = '{1'b0, 6'd31, 32'h0,        32'h80000001, 1'b0, 1'b1, 36, 12};
      vt[12] = '{1'b0, 6'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b1, 36, 12};

      rst = 1'b1; mem_clr = 1'b1; ram_en = 1'b1;
      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_reg = 6'd0; cmd_wdata = 32'd0; rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset flags b1", 32'({cmd_ready_1, rreq_1, wreq_1, wen0_1, wen1_1, rsp_valid_1,
                                 rsp_err_1, wdata0_1, wdata1_1}), 32'h100);
      chk("reset flags b4", 32'({cmd_ready_4, rreq_4, wreq_4, wen0_4, wen1_4, rsp_valid_4,
                                 rsp_err_4, wdata0_4, wdata1_4}), 32'h4000);
      chk("reset rdata b1", rsp_rdata_1, 32'h0);
      chk("reset rdata b4", rsp_rdata_4, 32'h0);
      rst = 1'b0; mem_clr = 1'b0;

      for (int i = 0; i < 13; i++) begin
         w1 = wen_cnt1; r1 = rreq_cnt1; q1 = wreq_cnt1;
         w4 = wen_cnt4; r4 = rreq_cnt4; q4 = wreq_cnt4;
         run_cmd(vt[i].we, vt[i].rg, vt[i].wdata, rd1, rd4, e1, e4, l1, l4);
         chk($sformatf("v%0d rdata b1", i), rd1, vt[i].exp_rdata);
         chk($sformatf("v%0d rdata b4", i), rd4, vt[i].exp_rdata);
         chk($sformatf("v%0d err b1", i), 32'(e1), 32'(vt[i].exp_err));
         chk($sformatf("v%0d err b4", i), 32'(e4), 32'(vt[i].exp_err));
         if (vt[i].exp_lat1 == 0) begin
            chk($sformatf("v%0d lat<=2 b1", i), 32'(l1 >= 1 && l1 <= 2), 32'd1);
            chk($sformatf("v%0d lat<=2 b4", i), 32'(l4 >= 1 && l4 <= 2), 32'd1);
         end else begin
            chk($sformatf("v%0d lat b1", i), 32'(l1), 32'(vt[i].exp_lat1));
            chk($sformatf("v%0d lat b4", i), 32'(l4), 32'(vt[i].exp_lat4));
         end
         chk($sformatf("v%0d traffic b1", i),
             {8'd0, 8'(wen_cnt1 - w1), 8'(rreq_cnt1 - r1), 8'(wreq_cnt1 - q1)},
             {8'd0, (vt[i].we && vt[i].serial) ? 8'd32 : 8'd0,
              8'(!vt[i].we && vt[i].serial), 8'(vt[i].we && vt[i].serial)});
         chk($sformatf("v%0d traffic b4", i),
             {8'd0, 8'(wen_cnt4 - w4), 8'(rreq_cnt4 - r4), 8'(wreq_cnt4 - q4)},
             {8'd0, (vt[i].we && vt[i].serial) ? 8'd8 : 8'd0,
              8'(!vt[i].we && vt[i].serial), 8'(vt[i].we && vt[i].serial)});
         if (vt[i].we && vt[i].serial) begin
            chk($sformatf("v%0d serial wdata b1", i), wcap1, vt[i].wdata);
            chk($sformatf("v%0d serial wdata b4", i), wcap4, vt[i].wdata);
         end
      end

      // Response backpressure: held response stays stable, no command accepted
      @(negedge clk);
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_reg = 6'd33;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      for (int c = 0; c < 100 && !rsp_valid_1; c++) @(negedge clk);
      chk("bp valid seen", 32'(rsp_valid_1), 32'd1);
      ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (!(rsp_valid_1 && rsp_rdata_1 == 32'h12345678 && !rsp_err_1 && !cmd_ready_1 &&
               rsp_valid_4 && rsp_rdata_4 == 32'h12345678 && !cmd_ready_4)) ok = 1'b0;
      end
      chk("bp stable", 32'(ok), 32'd1);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk("bp back to idle", 32'({rsp_valid_1, cmd_ready_1, rsp_rdata_1 == 32'd0}), 32'b011);

      // Reset during WSHIFT beat 10 of a write to reg 7
      @(negedge clk);
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_reg = 6'd7; cmd_wdata = 32'hFFFFFFFF;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      beats = 0; found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk);
         if (wen0_1) begin
            if (beats == 10) begin rst = 1'b1; found = 1'b1; end
            beats++;
         end
      end
      chk("reset beat found", 32'(found), 32'd1);
      @(negedge clk);
      chk("mid-write reset b1", 32'({wen0_1, wreq_1, rsp_valid_1, cmd_ready_1}), 32'b0001);
      chk("mid-write reset b4", 32'({wen0_4, rsp_valid_4, cmd_ready_4}), 32'b001);
      chk("partial write", mem1[7], 32'h000007FF);
      @(negedge clk);
      rst = 1'b0;

      // Grant never arrives
      ram_en = 1'b0;
`ifdef QERV_RF_HOST_TIMEOUT_EN
      run_cmd(1'b0, 6'd5, 32'd0, rd1, rd4, e1, e4, l1, l4);
      chk("timeout lat b1", 32'(l1), 32'd17);
      chk("timeout lat b4", 32'(l4), 32'd17);
      chk("timeout err", 32'({e1, e4}), 32'b11);
      chk("timeout rdata b1", rd1, 32'd0);
      chk("timeout rdata b4", rd4, 32'd0);
`else
      @(negedge clk);
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_reg = 6'd5;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      ok = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (rsp_valid_1 || rsp_valid_4 || cmd_ready_1 || cmd_ready_4) ok = 1'b0;
      end
      chk("no timeout wait", 32'(ok), 32'd1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
`endif
      ram_en = 1'b1;
      run_cmd(1'b0, 6'd5, 32'd0, rd1, rd4, e1, e4, l1, l4);
      chk("final read b1", rd1, 32'hDEADBEEF);
      chk("final read b4", rd4, 32'hDEADBEEF);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
